ex_mem_skid_stage: RTL

EX_MEM_SKID_STAGE -- requirements
Module: ex_mem_skid_stage

---
 rtl/ex_mem_skid_stage_if.sv | 34 +++
 rtl/ex_mem_skid_stage.sv | 122 ++++++++++++
 2 files changed

// File: rtl/ex_mem_skid_stage_if.sv
// EX->MEM handshake bundle: EX-side payload in, MEM-side payload out.
// master = producer/consumer environment, slave = the pipeline stage.
interface ex_mem_skid_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_wd;
  logic              in_wreg;
  logic [DATA_W-1:0] in_wdata;
  logic              in_enhilo;
  logic [DATA_W-1:0] in_hi;
  logic [DATA_W-1:0] in_lo;

  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_wd;
  logic              out_wreg;
  logic [DATA_W-1:0] out_wdata;
  logic              out_enhilo;
  logic [DATA_W-1:0] out_hi;
  logic [DATA_W-1:0] out_lo;

  modport master (
    output in_valid, in_wd, in_wreg, in_wdata, in_enhilo, in_hi, in_lo, out_ready,
    input  in_ready, out_valid, out_wd, out_wreg, out_wdata, out_enhilo, out_hi, out_lo
  );

  modport slave (
    input  in_valid, in_wd, in_wreg, in_wdata, in_enhilo, in_hi, in_lo, out_ready,
    output in_ready, out_valid, out_wd, out_wreg, out_wdata, out_enhilo, out_hi, out_lo
  );
endinterface

// File: rtl/ex_mem_skid_stage.sv
// EX/MEM pipeline register with optional skid buffer (EX_MEM_SKID_STAGE_SKID_BUF_EN);
// without the macro it is a single register with combinational in_ready.
module ex_mem_skid_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  ex_mem_skid_stage_if.slave   bus,
  output logic [1:0]           occ
);
  typedef struct packed {
    logic [ADDR_W-1:0] wd;
    logic              wreg;
    logic [DATA_W-1:0] wdata;
    logic              enhilo;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } entry_t;

  entry_t in_e, m_q, m_n;
  logic   m_valid_q, m_valid_n;
  logic   accept, retire, m_free;

  always_comb begin
    in_e.wd     = bus.in_wd;
    in_e.wreg   = bus.in_wreg;
    in_e.wdata  = bus.in_wdata;
    in_e.enhilo = bus.in_enhilo;
    in_e.hi     = bus.in_hi;
    in_e.lo     = bus.in_lo;
  end

  assign retire = m_valid_q & bus.out_ready;
  assign m_free = ~m_valid_q | retire;
  assign accept = bus.in_valid & bus.in_ready;

`ifdef EX_MEM_SKID_STAGE_SKID_BUF_EN
  entry_t s_q, s_n;
  logic   s_valid_q, s_valid_n;
  logic   in_ready_q;

  // in_ready_q is only deasserted while S holds an entry, so an accept with
  // M stalled always lands in an empty S.
  always_comb begin
    m_n       = m_q;
    s_n       = s_q;
    m_valid_n = m_valid_q;
    s_valid_n = s_valid_q;
    if (flush) begin
      m_valid_n = 1'b0;
      s_valid_n = 1'b0;
    end else if (m_free) begin
      if (s_valid_q) begin
        m_n       = s_q;
        m_valid_n = 1'b1;
        if (accept) s_n = in_e;
        else        s_valid_n = 1'b0;
      end else begin
        m_valid_n = accept;
        if (accept) m_n = in_e;
      end
    end else if (accept) begin
      s_n       = in_e;
      s_valid_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      m_q        <= '0;
      s_q        <= '0;
      m_valid_q  <= 1'b0;
      s_valid_q  <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      m_q        <= m_n;
      s_q        <= s_n;
      m_valid_q  <= m_valid_n;
      s_valid_q  <= s_valid_n;
      in_ready_q <= ~s_valid_n;
    end
  end

  assign bus.in_ready = in_ready_q;
  assign occ          = {1'b0, m_valid_q} + {1'b0, s_valid_q};
`else
  always_comb begin
    m_n       = m_q;
    m_valid_n = m_valid_q;
    if (flush) begin
      m_valid_n = 1'b0;
    end else if (m_free) begin
      m_valid_n = accept;
      if (accept) m_n = in_e;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      m_q       <= '0;
      m_valid_q <= 1'b0;
    end else begin
      m_q       <= m_n;
      m_valid_q <= m_valid_n;
    end
  end

  assign bus.in_ready = rst & (~m_valid_q | bus.out_ready);
  assign occ          = {1'b0, m_valid_q};
`endif

  // Write enables are gated so a bubble never commits a register write.
  assign bus.out_valid  = m_valid_q;
  assign bus.out_wd     = m_q.wd;
  assign bus.out_wreg   = m_q.wreg & m_valid_q;
  assign bus.out_wdata  = m_q.wdata;
  assign bus.out_enhilo = m_q.enhilo & m_valid_q;
  assign bus.out_hi     = m_q.hi;
  assign bus.out_lo     = m_q.lo;
endmodule
